fsm_combine: RTL and testbench

- HARQ soft-combining controller for the receive chain. It takes 16 signed 6-bit LLRs per beat from the rate-dematching stage (RDM) and accumulates them into a circular per-user buffer of 10-bit soft values.
- The buffer is one half of an internal ping/pong pair. The opposite half holds the previous result for the HARQ-send stage.
- Buffers swap after the send stage reports completion.

---
 rtl/fsm_combine.sv | 269 ++++++++++++++++++++++++++
 tb/tb_fsm_combine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_combine.sv
//----------------------------------------------------------------------------
// fsm_combine
//
// HARQ soft-combining controller. Each beat delivers LANES signed LLRs from
// the rate-dematching stage. They are accumulated into the active half of a
// ping/pong pair of soft-value buffers. The buffer is addressed circularly
// over ceil(Ncb/LANES) beats, so repeated passes over the same addresses keep
// combining. The inactive half holds the previous result for the HARQ-send
// stage. The halves swap once that stage reports completion.
//
// Optional feature macro: COMBINE_SAT_EN
//   defined   -> combined values saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]
//   undefined -> combined values wrap modulo 2^ACC_W (two's complement)
//
// Ports:
//   i_core_clk                 sole clock, rising edge
//   i_rx_rstn                  async active-high datapath reset (read regs,
//                              written flags, ping/pong select; also idles
//                              the FSM)
//   i_rx_fsm_rstn              async active-high FSM reset (state, address,
//                              latched user)
//   i_Combine_process_request  level request, sampled in IDLE
//   i_Combine_user_index       user select, bits [2:0] used
//   i_RDM_Data_Valid           beat qualifier
//   i_RDM_Data_Content         LANES x LLR_W LLRs, lane k at [LLR_W*k +: LLR_W]
//   i_RDM_Data_Comp            end of RDM stream
//   i_users_ncb                NUM_USERS x 16-bit Ncb, user u at [16u +: 16]
//   i_SENDHARQ_Data_Comp       send stage finished with the inactive buffer
//   DualPort_SRAM_COMB_Ping_Buffer_Read_Data  registered Ping read at the
//                              combine address, lane k at [ACC_W*k +: ACC_W]
//   DualPort_SRAM_COMB_Pong_Buffer_Read_Data  same for Pong
//   o_Combine_done             one-cycle pulse when the buffers swap
//----------------------------------------------------------------------------
module fsm_combine #(
  parameter int NUM_USERS = 8,
  parameter int LANES     = 16,
  parameter int LLR_W     = 6,
  parameter int ACC_W     = 10,
  parameter int DEPTH     = 64
) (
  input  logic                       i_core_clk,
  input  logic                       i_rx_rstn,
  input  logic                       i_rx_fsm_rstn,
  input  logic                       i_Combine_process_request,
  input  logic [3:0]                 i_Combine_user_index,
  input  logic                       i_RDM_Data_Valid,
  input  logic [LANES*LLR_W-1:0]     i_RDM_Data_Content,
  input  logic                       i_RDM_Data_Comp,
  input  logic [16*NUM_USERS-1:0]    i_users_ncb,
  input  logic                       i_SENDHARQ_Data_Comp,
  output logic [LANES*ACC_W-1:0]     DualPort_SRAM_COMB_Ping_Buffer_Read_Data,
  output logic [LANES*ACC_W-1:0]     DualPort_SRAM_COMB_Pong_Buffer_Read_Data,
  output logic                       o_Combine_done
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BEAT_W = ADDR_W + 1;
  localparam int WORD_W = LANES * ACC_W;
  localparam int SUM_W  = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMBINE   = 2'd1,
    WAIT_SEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          user_q, user_d;
  logic                done_q, done_d;

  logic                fsm_held;
  logic                start_combine;
  logic                mem_we;
  logic                swap_bufs;

  logic                sel_q;
  logic [DEPTH-1:0]    ping_written, pong_written;
  logic [WORD_W-1:0]   ping_mem [DEPTH];
  logic [WORD_W-1:0]   pong_mem [DEPTH];
  logic [WORD_W-1:0]   ping_rd_q, pong_rd_q;

  logic [15:0]         ncb_cur;
  logic [12:0]         beats_raw;
  logic [BEAT_W-1:0]   beats;
  logic                last_addr;

  logic [WORD_W-1:0]   active_word;
  logic                active_flag;
  logic [WORD_W-1:0]   comb_word;

  // Only eight users exist, so the top bit of the user index is ignored.
  logic                unused_user_msb;
  assign unused_user_msb = i_Combine_user_index[3];

  // Either reset freezes the FSM, so no start/write/swap strobe can leak into
  // the datapath while the FSM is held in IDLE.
  assign fsm_held = i_rx_rstn | i_rx_fsm_rstn;

  // Combine one lane: start from the LLR alone on the first write of this
  // combine, otherwise add it to the stored soft value.
  function automatic logic [ACC_W-1:0] combine_lane(
    input logic [ACC_W-1:0] old_val,
    input logic             use_old,
    input logic [LLR_W-1:0] llr
  );
`ifdef COMBINE_SAT_EN
    logic [SUM_W-1:0] llr_x;
    logic [SUM_W-1:0] old_x;
    logic [SUM_W-1:0] sum;
    llr_x = {{(SUM_W-LLR_W){llr[LLR_W-1]}}, llr};
    old_x = use_old ? {old_val[ACC_W-1], old_val} : '0;
    sum   = llr_x + old_x;
    // One guard bit suffices: the sum overflowed exactly when the top two
    // bits disagree, and the top bit gives the direction.
    if (sum[SUM_W-1] != sum[SUM_W-2]) begin
      return sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return sum[ACC_W-1:0];
`else
    logic [ACC_W-1:0] llr_x;
    logic [ACC_W-1:0] old_x;
    llr_x = {{(ACC_W-LLR_W){llr[LLR_W-1]}}, llr};
    old_x = use_old ? old_val : '0;
    return llr_x + old_x;
`endif
  endfunction

  // Beats per pass for the latched user: ceil(Ncb/LANES), at least one and at
  // most the buffer depth. Ncb is treated as static configuration while a
  // combine is in progress.
  always_comb begin
    ncb_cur   = i_users_ncb[user_q*16 +: 16];
    beats_raw = {1'b0, ncb_cur[15:4]} + {12'd0, |ncb_cur[3:0]};
    if (beats_raw == '0) begin
      beats = BEAT_W'(1);
    end else if (beats_raw > 13'(DEPTH)) begin
      beats = BEAT_W'(DEPTH);
    end else begin
      beats = beats_raw[BEAT_W-1:0];
    end
    last_addr = ({1'b0, addr_q} == (beats - BEAT_W'(1)));
  end

  // Read-modify-write data for the active buffer at the current address.
  always_comb begin
    active_word = sel_q ? pong_mem[addr_q] : ping_mem[addr_q];
    active_flag = sel_q ? pong_written[addr_q] : ping_written[addr_q];
    comb_word   = '0;
    for (int k = 0; k < LANES; k++) begin
      comb_word[k*ACC_W +: ACC_W] = combine_lane(active_word[k*ACC_W +: ACC_W],
                                                 active_flag,
                                                 i_RDM_Data_Content[k*LLR_W +: LLR_W]);
    end
  end

  // Next-state and control strobes. Inputs that arrive outside the state
  // that uses them fall through to the defaults and are ignored.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    user_d        = user_q;
    done_d        = 1'b0;
    start_combine = 1'b0;
    mem_we        = 1'b0;
    swap_bufs     = 1'b0;
    if (!fsm_held) begin
      case (state_q)
        IDLE: begin
          if (i_Combine_process_request) begin
            user_d        = i_Combine_user_index[2:0];
            addr_d        = '0;
            start_combine = 1'b1;
            state_d       = COMBINE;
          end
        end
        COMBINE: begin
          if (i_RDM_Data_Valid) begin
            mem_we = 1'b1;
            addr_d = last_addr ? '0 : addr_q + ADDR_W'(1);
          end
          if (i_RDM_Data_Comp) begin
            state_d = WAIT_SEND;
          end
        end
        WAIT_SEND: begin
          if (i_SENDHARQ_Data_Comp) begin
            swap_bufs = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and done pulse: either reset returns the controller to IDLE at
  // once, discarding any partial combine.
  always_ff @(posedge i_core_clk or posedge i_rx_rstn or posedge i_rx_fsm_rstn) begin
    if (i_rx_rstn || i_rx_fsm_rstn) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Address and latched user belong to the FSM reset domain only.
  always_ff @(posedge i_core_clk or posedge i_rx_fsm_rstn) begin
    if (i_rx_fsm_rstn) begin
      addr_q <= '0;
      user_q <= '0;
    end else begin
      addr_q <= addr_d;
      user_q <= user_d;
    end
  end

  // Buffer storage has no reset; the written flags make stale contents
  // irrelevant to the next combine.
  always_ff @(posedge i_core_clk) begin
    if (mem_we) begin
      if (sel_q) begin
        pong_mem[addr_q] <= comb_word;
      end else begin
        ping_mem[addr_q] <= comb_word;
      end
    end
  end

  // Datapath registers: both read ports sample the current address every
  // cycle (pre-write contents), the written flags track which entries belong
  // to the combine in progress, and the select flips on each swap.
  always_ff @(posedge i_core_clk or posedge i_rx_rstn) begin
    if (i_rx_rstn) begin
      ping_rd_q    <= '0;
      pong_rd_q    <= '0;
      ping_written <= '0;
      pong_written <= '0;
      sel_q        <= 1'b0;
    end else begin
      ping_rd_q <= ping_mem[addr_q];
      pong_rd_q <= pong_mem[addr_q];
      if (start_combine) begin
        if (sel_q) begin
          pong_written <= '0;
        end else begin
          ping_written <= '0;
        end
      end else if (mem_we) begin
        if (sel_q) begin
          pong_written[addr_q] <= 1'b1;
        end else begin
          ping_written[addr_q] <= 1'b1;
        end
      end
      if (swap_bufs) begin
        sel_q <= ~sel_q;
      end
    end
  end

  assign DualPort_SRAM_COMB_Ping_Buffer_Read_Data = ping_rd_q;
  assign DualPort_SRAM_COMB_Pong_Buffer_Read_Data = pong_rd_q;
  assign o_Combine_done                           = done_q;

endmodule

// File: tb/tb_fsm_combine.sv
//----------------------------------------------------------------------------
// tb_fsm_combine
//
// Self-checking bench for fsm_combine. A behavioural model of the two soft
// buffers (plain integer arrays) tracks what every entry must hold and what
// each read register must show. It is compared against the DUT every cycle.
// Directed sequences pin the model with hand-computed values. A randomized
// phase follows.
//----------------------------------------------------------------------------
module tb_fsm_combine;

  localparam int NUM_USERS = 8;
  localparam int LANES     = 16;
  localparam int LLR_W     = 6;
  localparam int ACC_W     = 10;
  localparam int DEPTH     = 64;
  localparam int DW        = LANES * ACC_W;

  logic tb_sclk = 1'b0;
  always #5 tb_sclk = ~tb_sclk;

  logic                     rx_rstn;
  logic                     fsm_rstn;
  logic                     req;
  logic [3:0]               user_idx;
  logic                     valid;
  logic [LANES*LLR_W-1:0]   rdm_data;
  logic                     comp;
  logic [16*NUM_USERS-1:0]  users_ncb;
  logic                     send_comp;
  logic [DW-1:0]            ping_rd;
  logic [DW-1:0]            pong_rd;
  logic                     done;

  fsm_combine #(
    .NUM_USERS(NUM_USERS), .LANES(LANES), .LLR_W(LLR_W), .ACC_W(ACC_W), .DEPTH(DEPTH)
  ) dut (
    .i_core_clk                               (tb_sclk),
    .i_rx_rstn                                (rx_rstn),
    .i_rx_fsm_rstn                            (fsm_rstn),
    .i_Combine_process_request                (req),
    .i_Combine_user_index                     (user_idx),
    .i_RDM_Data_Valid                         (valid),
    .i_RDM_Data_Content                       (rdm_data),
    .i_RDM_Data_Comp                          (comp),
    .i_users_ncb                              (users_ncb),
    .i_SENDHARQ_Data_Comp                     (send_comp),
    .DualPort_SRAM_COMB_Ping_Buffer_Read_Data (ping_rd),
    .DualPort_SRAM_COMB_Pong_Buffer_Read_Data (pong_rd),
    .o_Combine_done                           (done)
  );

  int vectors     = 0;
  int miscompares = 0;
  int done_count  = 0;

  // Model: buffer contents, per-combine written flags, and which entries have
  // ever been written (unwritten storage has no defined value).
  int  m     [2][DEPTH][LANES];
  bit  f     [2][DEPTH];
  bit  known [2][DEPTH];
  int  sel_m   = 0;
  int  phase   = 0;   // 0 idle, 1 combining, 2 waiting for send stage
  int  addr_m  = 0;
  int  beats_m = 1;
  int  exp_rd [2][LANES];
  bit  exp_known [2];
  bit  exp_done = 1'b0;

`ifdef COMBINE_SAT_EN
  localparam int POS_RESULT = 511;
  localparam int NEG_RESULT = -512;
`else
  localparam int POS_RESULT = 17 * 31;
  localparam int NEG_RESULT = -17 * 32;
`endif

  function automatic int wrap_acc(int v);
    int r;
    r = v & 1023;
    if (r >= 512) r -= 1024;
    return r;
  endfunction

  function automatic int combine_val(int old_v, int llr);
    int s;
    s = old_v + llr;
`ifdef COMBINE_SAT_EN
    if (s > 511) s = 511;
    if (s < -512) s = -512;
    return s;
`else
    return wrap_acc(s);
`endif
  endfunction

  function automatic logic [DW-1:0] splat(int v);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*ACC_W +: ACC_W] = 10'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] pack_exp(int b);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*ACC_W +: ACC_W] = 10'(exp_rd[b][k]);
    return r;
  endfunction

  function automatic logic [LANES*LLR_W-1:0] fill(int llr);
    logic [LANES*LLR_W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*LLR_W +: LLR_W] = 6'(llr);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    int  nrd [2][LANES];
    bit  nk  [2];
    int  ncb;
    logic signed [LLR_W-1:0] l;
    int  li;
    int  old_v;
    if (rx_rstn || fsm_rstn) begin
      phase    = 0;
      exp_done = 1'b0;
      if (fsm_rstn) addr_m = 0;
      if (rx_rstn) begin
        sel_m = 0;
        for (int b = 0; b < 2; b++) begin
          for (int a = 0; a < DEPTH; a++) f[b][a] = 1'b0;
          for (int k = 0; k < LANES; k++) exp_rd[b][k] = 0;
          exp_known[b] = 1'b1;
        end
      end else begin
        for (int b = 0; b < 2; b++) begin
          for (int k = 0; k < LANES; k++) exp_rd[b][k] = m[b][addr_m][k];
          exp_known[b] = known[b][addr_m];
        end
      end
      return;
    end
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < LANES; k++) nrd[b][k] = m[b][addr_m][k];
      nk[b] = known[b][addr_m];
    end
    exp_done = 1'b0;
    case (phase)
      0: if (req) begin
        ncb = int'(users_ncb[(user_idx % 8)*16 +: 16]);
        beats_m = (ncb + 15) / 16;
        if (beats_m == 0) beats_m = 1;
        if (beats_m > DEPTH) beats_m = DEPTH;
        for (int a = 0; a < DEPTH; a++) f[sel_m][a] = 1'b0;
        addr_m = 0;
        phase  = 1;
      end
      1: begin
        if (valid) begin
          for (int k = 0; k < LANES; k++) begin
            l = rdm_data[k*LLR_W +: LLR_W];
            li = l;
            old_v = f[sel_m][addr_m] ? m[sel_m][addr_m][k] : 0;
            m[sel_m][addr_m][k] = combine_val(old_v, li);
          end
          f[sel_m][addr_m]     = 1'b1;
          known[sel_m][addr_m] = 1'b1;
          addr_m = (addr_m + 1) % beats_m;
        end
        if (comp) phase = 2;
      end
      default: if (send_comp) begin
        sel_m    = 1 - sel_m;
        exp_done = 1'b1;
        phase    = 0;
      end
    endcase
    exp_rd    = nrd;
    exp_known = nk;
  endtask

  // Per-cycle compare, 1 time unit after the rising edge.
  always @(posedge tb_sclk) begin
    model_step();
    #1;
    if (exp_known[0]) checkOutput("ping_rd", ping_rd, pack_exp(0));
    if (exp_known[1]) checkOutput("pong_rd", pong_rd, pack_exp(1));
    checkOutput("done", DW'(done), DW'(exp_done));
    if (done === 1'b1) done_count++;
  end

  // Drive one cycle of inputs at a falling edge, then wait for the next one.
  task automatic applyStimulus(input bit r, input int u, input bit v,
                               input logic [LANES*LLR_W-1:0] d, input bit c, input bit s);
    req       = r;
    user_idx  = 4'(u);
    valid     = v;
    rdm_data  = d;
    comp      = c;
    send_comp = s;
    @(negedge tb_sclk);
  endtask

  task automatic finish_combine();
    applyStimulus(0, 0, 0, '0, 1, 0);
    applyStimulus(0, 0, 0, '0, 0, 1);
    applyStimulus(0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    rx_rstn   = 1'b1;
    fsm_rstn  = 1'b1;
    req       = 1'b0;
    user_idx  = '0;
    valid     = 1'b0;
    rdm_data  = '0;
    comp      = 1'b0;
    send_comp = 1'b0;
    // users 7..0
    users_ncb = {16'd1008, 16'd17, 16'd1024, 16'd2000, 16'd0, 16'd40, 16'd100, 16'd16};
    repeat (3) @(negedge tb_sclk);
    checkOutput("reset_ping", ping_rd, '0);
    checkOutput("reset_pong", pong_rd, '0);
    checkOutput("reset_done", DW'(done), '0);
    rx_rstn  = 1'b0;
    fsm_rstn = 1'b0;
    @(negedge tb_sclk);

    // User 1, Ncb 100 -> 7 beats; 20 beats of +1 with a 2-cycle gap.
    applyStimulus(1, 1, 0, '0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) repeat (2) applyStimulus(0, 0, 0, fill(7), 0, 0);
      applyStimulus(0, 0, 1, fill(1), 0, 0);
    end
    applyStimulus(0, 0, 0, '0, 0, 0);
    checkOutput("c1_entry6", ping_rd, splat(2));
    checkOutput("model_e0", DW'(m[0][0][0]), DW'(3));
    checkOutput("model_e5", DW'(m[0][5][15]), DW'(3));
    checkOutput("model_e6", DW'(m[0][6][3]), DW'(2));

    // Comp with send-comp held high -> exactly one done pulse.
    applyStimulus(0, 0, 0, '0, 1, 1);
    repeat (3) applyStimulus(0, 0, 0, '0, 0, 1);
    applyStimulus(0, 0, 0, '0, 0, 0);
    checkOutput("done_once", DW'(done_count), DW'(1));

    // Next combine lands in Pong with fresh values; Ping retained.
    applyStimulus(1, 1, 0, '0, 0, 0);
    repeat (7) applyStimulus(0, 0, 1, fill(1), 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 0);
    checkOutput("c2_pong_fresh", pong_rd, splat(1));
    checkOutput("c2_ping_kept", ping_rd, splat(3));
    finish_combine();
    checkOutput("done_twice", DW'(done_count), DW'(2));

    // +31 for 17 passes of a 1-beat buffer (Ping).
    applyStimulus(1, 0, 0, '0, 0, 0);
    repeat (17) applyStimulus(0, 0, 1, fill(31), 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 0);
    checkOutput("sat_pos", ping_rd, splat(POS_RESULT));
    finish_combine();

    // FSM reset mid-combine (Pong active): no done pulse, select unchanged.
    applyStimulus(1, 2, 0, '0, 0, 0);
    repeat (2) applyStimulus(0, 0, 1, {$urandom, $urandom, $urandom}, 0, 0);
    fsm_rstn = 1'b1;
    repeat (2) applyStimulus(0, 0, 1, fill(3), 1, 1);
    fsm_rstn = 1'b0;
    repeat (2) applyStimulus(0, 0, 0, '0, 0, 1);
    checkOutput("reset_no_done", DW'(done_count), DW'(3));

    // -32 for 17 passes; must land in Pong, proving the select survived.
    applyStimulus(1, 0, 0, '0, 0, 0);
    repeat (17) applyStimulus(0, 0, 1, fill(-32), 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 0);
    checkOutput("sat_neg", pong_rd, splat(NEG_RESULT));
    finish_combine();

    // Randomized traffic, including occasional resets of either kind.
    for (int i = 0; i < 3000; i++) begin
      rx_rstn  = ($urandom % 400 == 0);
      fsm_rstn = ($urandom % 300 == 0);
      applyStimulus(($urandom % 4) == 0, int'($urandom % 16), ($urandom % 2) == 0,
                    {$urandom, $urandom, $urandom},
                    ($urandom % 24) == 0, ($urandom % 8) == 0);
    end
    rx_rstn  = 1'b0;
    fsm_rstn = 1'b0;
    repeat (2) applyStimulus(0, 0, 0, '0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
